// File: rtl/addsub_sequencer_if.sv
// Request/grant and result handshake bundle for addsub_sequencer.
// The sequencer uses the slave modport; requesters and the result consumer use the master modport.
interface addsub_sequencer_if #(
  parameter int WIDTH = 4
);
  logic             req0;
  logic             req1;
  logic             op0;
  logic             op1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             res_ready;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             res_valid;
  logic             res_id;
  logic [WIDTH-1:0] result;
  logic             carry_out;

  modport slave (
    input  req0, req1, op0, op1, a0, b0, a1, b1, res_ready,
    output gnt0, gnt1, busy, res_valid, res_id, result, carry_out
  );

  modport master (
    output req0, req1, op0, op1, a0, b0, a1, b1, res_ready,
    input  gnt0, gnt1, busy, res_valid, res_id, result, carry_out
  );
endinterface

// File: rtl/addsub_sequencer.sv
// Two-requester sequencer for a shared ripple full-adder: add, or ones'-complement subtract in two passes.
// Define RR_ARB_EN for round-robin arbitration; leave it undefined for fixed priority (requester 0 wins).
module addsub_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  addsub_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PASS1 = 2'd1,
    S_PASS2 = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op;
  logic             r_id;
  logic [WIDTH-1:0] r_s1;
  logic             r_c1;

  logic             r_gnt0;
  logic             r_gnt1;
  logic             r_busy;
  logic             r_res_valid;
  logic             r_res_id;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;

  logic             w_any_req;
  logic             w_win;
  logic             w_grant;
  logic             w_gnt0_next;
  logic             w_gnt1_next;
  logic             w_busy_next;
  logic             w_res_valid_next;

  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic             w_add_cin;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH:0]   w_carry;

  assign w_any_req = bus.req0 | bus.req1;

`ifdef RR_ARB_EN
  logic r_last;

  // On contention the requester not served last wins; a lone request always wins.
  assign w_win = (bus.req0 & bus.req1) ? ~r_last : bus.req1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_win;
    end
  end
`else
  assign w_win = ~bus.req0;
`endif

  always_comb begin
    w_next_state     = r_state;
    w_grant          = 1'b0;
    w_gnt0_next      = 1'b0;
    w_gnt1_next      = 1'b0;
    w_busy_next      = 1'b0;
    w_res_valid_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_grant      = 1'b1;
          w_next_state = S_PASS1;
        end
      end
      S_PASS1: w_next_state = S_PASS2;
      S_PASS2: w_next_state = S_DONE;
      S_DONE: begin
        if (r_res_valid && bus.res_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
    w_gnt0_next      = w_grant & ~w_win;
    w_gnt1_next      = w_grant & w_win;
    w_busy_next      = (w_next_state != S_IDLE);
    w_res_valid_next = (w_next_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_gnt0      <= w_gnt0_next;
      r_gnt1      <= w_gnt1_next;
      r_busy      <= w_busy_next;
      r_res_valid <= w_res_valid_next;
    end
  end

  // One adder serves both passes: A + (B or ~B) first, then s1 + end-around carry.
  always_comb begin
    w_add_a   = r_a;
    w_add_b   = r_op ? ~r_b : r_b;
    w_add_cin = 1'b0;
    if (r_state == S_PASS2) begin
      w_add_a   = r_s1;
      w_add_b   = '0;
      w_add_cin = r_op & r_c1;
    end
  end

  assign w_carry[0] = w_add_cin;

  generate
    for (genvar g = 0; g < WIDTH; g++) begin : g_full_adder
      assign w_sum[g]       = w_add_a[g] ^ w_add_b[g] ^ w_carry[g];
      assign w_carry[g + 1] = (w_add_a[g] & w_add_b[g]) | (w_carry[g] & (w_add_a[g] ^ w_add_b[g]));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= 1'b0;
      r_id        <= 1'b0;
      r_s1        <= '0;
      r_c1        <= 1'b0;
      r_res_id    <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else begin
      if (w_grant) begin
        r_a  <= w_win ? bus.a1  : bus.a0;
        r_b  <= w_win ? bus.b1  : bus.b0;
        r_op <= w_win ? bus.op1 : bus.op0;
        r_id <= w_win;
      end
      if (r_state == S_PASS1) begin
        r_s1 <= w_sum;
        r_c1 <= w_carry[WIDTH];
      end
      // Second-pass carry-out is always 0 for valid inputs, so only the sum is kept.
      if (r_state == S_PASS2) begin
        r_result    <= w_sum;
        r_carry_out <= r_c1;
        r_res_id    <= r_id;
      end
    end
  end

  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.busy      = r_busy;
  assign bus.res_valid = r_res_valid;
  assign bus.res_id    = r_res_id;
  assign bus.result    = r_result;
  assign bus.carry_out = r_carry_out;

endmodule
